// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one palette ROM, 2-stage registered lookup.
// Define PALETTE_FADE_EN to add the fade_lvl per-channel dimming input.
module palette_lookup_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [3:0]           pal_index,
  input  logic [11:0]          pal_rgb,
`ifdef PALETTE_FADE_EN
  input  logic [3:0]           fade_lvl,
`endif
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [11:0]          rsp_rgb,
  output logic                 busy
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] nxt_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [3:0]      gnt_idx;
  logic            found;
  logic            s1_v;
  logic [ID_W-1:0] s1_id;
  logic [11:0]     rgb_next;

  // Pick first requester at or above rr_ptr, else wrap to lowest one.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (!Reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[k] && (ID_W'(k) >= rr_ptr)) begin
          found   = 1'b1;
          gnt[k]  = 1'b1;
          gnt_id  = ID_W'(k);
          gnt_idx = req_idx[4*k +: 4];
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[k]) begin
          found   = 1'b1;
          gnt[k]  = 1'b1;
          gnt_id  = ID_W'(k);
          gnt_idx = req_idx[4*k +: 4];
        end
      end
    end
  end

  // Pointer moves one past the winner, wrapping at NUM_REQ.
  always_comb begin
    nxt_ptr = gnt_id + ID_W'(1);
    if ({1'b0, gnt_id} == (ID_W+1)'(NUM_REQ - 1)) begin
      nxt_ptr = '0;
    end
  end

`ifdef PALETTE_FADE_EN
  function automatic logic [3:0] dim(
    input logic [3:0] ch,
    input logic [3:0] lvl
  );
    return (ch > lvl) ? (ch - lvl) : 4'd0;
  endfunction

  assign rgb_next = {dim(pal_rgb[11:8], fade_lvl),
                     dim(pal_rgb[7:4], fade_lvl),
                     dim(pal_rgb[3:0], fade_lvl)};
`else
  assign rgb_next = pal_rgb;
`endif

  // Stage 1: accept the granted lookup and drive the ROM index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr    <= '0;
      s1_v      <= 1'b0;
      s1_id     <= '0;
      pal_index <= '0;
    end else begin
      s1_v <= found;
      if (found) begin
        rr_ptr    <= nxt_ptr;
        s1_id     <= gnt_id;
        pal_index <= gnt_idx;
      end
    end
  end

  // Stage 2: register ROM data; colour holds between responses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rgb   <= '0;
    end else begin
      rsp_valid <= s1_v;
      rsp_id    <= s1_id;
      if (s1_v) begin
        rsp_rgb <= rgb_next;
      end
    end
  end

  assign busy = s1_v | rsp_valid;

endmodule
